sram_controller: RTL and testbench

Memory-stage responder between the pipeline's MEM stage and an external 16-bit asynchronous SRAM. It converts one 32-bit word read or write into two 16-bit SRAM accesses with fixed wait states. While the access is in progress it holds `ready` low, and that signal drives the freeze (`ld` deassert) of the pipeline registers. It is the far end of the register load/hold control, generating the stall that the pipeline registers obey.

---
 rtl/sram_controller.sv | 166 ++++++++++++++++
 tb/tb_sram_controller.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//
// Memory-stage responder between the pipeline MEM stage and an external
// 16-bit asynchronous SRAM. One 32-bit word access becomes two 16-bit SRAM
// accesses (low half first, then high half). Each half takes HALF_CYCLES
// clocks. The combinational o_ready output is the pipeline-register load
// enable, so holding it low freezes the pipeline.
//
// Handshake: the MEM stage raises i_wr_en or i_rd_en together with
// i_address / i_write_data. It keeps all of them stable while o_ready is 0.
// o_ready = ~(i_wr_en | i_rd_en) | (state == DONE). The cycle in which
// o_ready is 1 with a request present is the completion cycle. At the
// following edge the pipeline advances. A request present in the next IDLE
// cycle starts a new access.
//
// Parameters
//   HALF_CYCLES  clocks per 16-bit half access (legal 2..15)
//   ADDR_W       SRAM half-word address width
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_wr_en        word write request (wins over i_rd_en)
//   i_rd_en        word read request
//   i_address      byte address, word index = i_address[ADDR_W:2]
//   i_write_data   word to store
//   o_read_data    registered result of the last read
//   o_ready        1: MEM stage may advance, 0: freeze pipeline
//   o_sram_addr    SRAM half-word address {word index, half}
//   io_sram_dq     SRAM data bus, driven only during write phases
//   o_sram_we_n    SRAM write strobe, active low
//   o_dbg_state    current FSM state (IDLE/LOW/HIGH/DONE)
//   o_dbg_cnt      current phase counter
//   o_dbg_dq_oe    1 while this block drives io_sram_dq
// ---------------------------------------------------------------------------
module sram_controller #(
  parameter int HALF_CYCLES = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  input  logic [31:0]       i_address,
  input  logic [31:0]       i_write_data,
  output logic [31:0]       o_read_data,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire logic [15:0]  io_sram_dq,
  output logic              o_sram_we_n,
  output logic [1:0]        o_dbg_state,
  output logic [3:0]        o_dbg_cnt,
  output logic              o_dbg_dq_oe
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Terminal value of the per-half phase counter.
  localparam logic [3:0] CNT_LAST = 4'(HALF_CYCLES - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_is_wr;
  logic [31:0] r_read_data;

  logic        w_req;
  logic        w_last;
  logic        w_in_phase;
  logic        w_phase_hi;
  logic        w_drive;
  logic        w_strobe;
  logic [15:0] w_wdata_half;

  // Only the word-index bits of the address reach the SRAM.
  logic        w_unused_addr;
  assign w_unused_addr = ^{i_address[31:ADDR_W+1], i_address[1:0]};

  assign w_req      = i_wr_en | i_rd_en;
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_phase_hi = (r_state == S_HIGH);
  assign w_in_phase = (r_state == S_LOW) | w_phase_hi;

  // ---------------------------------------------------------------------------
  // State, phase counter, operation type and read capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_is_wr     <= 1'b0;
      r_read_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 4'd0;
          if (w_req) begin
            r_state <= S_LOW;
            // Write wins when both requests are raised together.
            r_is_wr <= i_wr_en;
          end
        end
        S_LOW: begin
          if (w_last) begin
            r_state <= S_HIGH;
            r_cnt   <= 4'd0;
            // The SRAM output has settled by the end of the phase.
            if (!r_is_wr) begin
              r_read_data[15:0] <= io_sram_dq;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_HIGH: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_cnt   <= 4'd0;
            if (!r_is_wr) begin
              r_read_data[31:16] <= io_sram_dq;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM pins
  // ---------------------------------------------------------------------------
  // Data is driven for the whole phase. The strobe is released on the
  // final cycle, so the data still holds at the rising edge of we_n.
  assign w_drive      = r_is_wr & w_in_phase;
  assign w_strobe     = w_drive & ~w_last;
  assign w_wdata_half = w_phase_hi ? i_write_data[31:16] : i_write_data[15:0];

  assign io_sram_dq  = w_drive ? w_wdata_half : 16'hzzzz;
  assign o_sram_we_n = ~w_strobe;

  // Outside the HIGH phase the address shows the word's low half.
  assign o_sram_addr = {i_address[ADDR_W:2], w_phase_hi};

  // ---------------------------------------------------------------------------
  // Pipeline side
  // ---------------------------------------------------------------------------
  assign o_ready     = ~w_req | (r_state == S_DONE);
  assign o_read_data = r_read_data;

  assign o_dbg_state = r_state;
  assign o_dbg_cnt   = r_cnt;
  assign o_dbg_dq_oe = w_drive;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;
  localparam int H  = 2;
  localparam int H4 = 4;
  localparam int AW = 18;
  localparam int MEMN = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // ---------------- main DUT (H = 2) ----------------
  logic          wr_en, rd_en;
  logic [31:0]   address, write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n;
  logic [1:0]    dbg_state;
  logic [3:0]    dbg_cnt;
  logic          dq_oe;
  wire  [15:0]   sram_dq;

  logic [15:0] sram_mem  [0:MEMN-1];
  logic [15:0] model_mem [0:MEMN-1];

  assign sram_dq = dq_oe ? 16'hzzzz : sram_mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] = sram_dq;

  sram_controller #(.HALF_CYCLES(H), .ADDR_W(AW)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_rd_en(rd_en),
    .i_address(address), .i_write_data(write_data),
    .o_read_data(read_data), .o_ready(ready), .o_sram_addr(sram_addr),
    .io_sram_dq(sram_dq), .o_sram_we_n(sram_we_n),
    .o_dbg_state(dbg_state), .o_dbg_cnt(dbg_cnt), .o_dbg_dq_oe(dq_oe)
  );

  // ---------------- second DUT (H = 4) ----------------
  logic          wr4, rd4;
  logic [31:0]   addr4, wd4;
  logic [31:0]   read_data4;
  logic          ready4;
  logic [AW-1:0] sram_addr4;
  logic          we_n4;
  logic [1:0]    dbg_state4;
  logic [3:0]    dbg_cnt4;
  logic          dq_oe4;
  wire  [15:0]   dq4;
  logic [15:0]   mem4 [0:MEMN-1];

  assign dq4 = dq_oe4 ? 16'hzzzz : mem4[sram_addr4];
  always @(posedge clk) if (!we_n4) mem4[sram_addr4] = dq4;

  sram_controller #(.HALF_CYCLES(H4), .ADDR_W(AW)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr4), .i_rd_en(rd4),
    .i_address(addr4), .i_write_data(wd4),
    .o_read_data(read_data4), .o_ready(ready4), .o_sram_addr(sram_addr4),
    .io_sram_dq(dq4), .o_sram_we_n(we_n4),
    .o_dbg_state(dbg_state4), .o_dbg_cnt(dbg_cnt4), .o_dbg_dq_oe(dq_oe4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_t counts cycles since the access was accepted: 0 = idle,
  // 1..H low half, H+1..2H high half, 2H+1 completion.
  int          m_t = 0;
  bit          m_wr = 1'b0;
  logic [31:0] m_rd = 32'd0;
  bit          cmp_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_t  = 0;
      m_rd = 32'd0;
    end else if (m_t == 0) begin
      if (wr_en | rd_en) begin
        m_t  = 1;
        m_wr = wr_en;
        if (wr_en) begin
          model_mem[{address[AW:2], 1'b0}] = write_data[15:0];
          model_mem[{address[AW:2], 1'b1}] = write_data[31:16];
        end
      end
    end else if (m_t == 2*H + 1) begin
      m_t = 0;
    end else begin
      if (!m_wr && m_t == H)   m_rd[15:0]  = model_mem[{address[AW:2], 1'b0}];
      if (!m_wr && m_t == 2*H) m_rd[31:16] = model_mem[{address[AW:2], 1'b1}];
      m_t++;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int ph, pos;
    logic          e_ready, e_we_n, e_oe;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_dq;
    if (cmp_en) begin
      e_ready = !(wr_en | rd_en) || (m_t == 2*H + 1);
      e_we_n  = 1'b1;
      e_oe    = 1'b0;
      e_addr  = {address[AW:2], 1'b0};
      e_dq    = 16'h0;
      if (m_t >= 1 && m_t <= 2*H) begin
        ph     = (m_t - 1) / H;
        pos    = (m_t - 1) % H;
        e_we_n = !(m_wr && pos < H - 1);
        e_oe   = m_wr;
        e_addr = {address[AW:2], ph[0]};
        e_dq   = (ph == 1) ? write_data[31:16] : write_data[15:0];
      end
      check("cyc_ready", 32'(ready), 32'(e_ready));
      check("cyc_we_n", 32'(sram_we_n), 32'(e_we_n));
      check("cyc_dq_oe", 32'(dq_oe), 32'(e_oe));
      check("cyc_addr", 32'(sram_addr), 32'(e_addr));
      check("cyc_read_data", read_data, m_rd);
      if (e_oe) check("cyc_dq", 32'(sram_dq), 32'(e_dq));
    end
  end

  // ---------------- scoreboard / drivers ----------------
  logic [31:0]   exp_q[$];
  logic [AW-1:0] tr_addr [0:63];
  logic          tr_we   [0:63];
  logic [15:0]   tr_dq   [0:63];
  int last_start_cyc, last_done_cyc;

  task automatic rec(input int k);
    if (k < 64) begin
      tr_addr[k] = sram_addr;
      tr_we[k]   = sram_we_n;
      tr_dq[k]   = sram_dq;
    end
  endtask

  function automatic int we_low_count(input int n);
    int c = 0;
    for (int k = 0; k <= n && k < 64; k++) if (tr_we[k] == 1'b0) c++;
    return c;
  endfunction

  task automatic wait_ready(output int lat);
    lat = 0;
    @(negedge clk); rec(0);
    while (!ready && lat < 60) begin
      @(negedge clk);
      lat++;
      rec(lat);
    end
    last_done_cyc = cyc;
    check("ready_seen", 32'(ready), 32'd1);
  endtask

  task automatic do_op(input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, output int lat);
    logic [31:0] e;
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; write_data = d;
    last_start_cyc = cyc;
    if (r && !w) exp_q.push_back({model_mem[{a[AW:2], 1'b1}], model_mem[{a[AW:2], 1'b0}]});
    wait_ready(lat);
    if (r && !w) begin
      e = exp_q.pop_front();
      check("sb_read_word", read_data, e);
    end
  endtask

  task automatic idle_cycles(input int n);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic do4(input bit w, input bit r, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output int wl);
    @(posedge clk); #1;
    wr4 = w; rd4 = r; addr4 = a; wd4 = d;
    last_start_cyc = cyc;
    lat = 0; wl = 0;
    @(negedge clk);
    while (!ready4 && lat < 60) begin
      if (!we_n4) wl++;
      @(negedge clk);
      lat++;
    end
    last_done_cyc = cyc;
    check("h4_ready_seen", 32'(ready4), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, wl, t0, kind;
    logic [31:0] a, d;
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b1; address = 32'h0000_0040; write_data = 32'h0;
    wr4 = 1'b0; rd4 = 1'b0; addr4 = 32'h0; wd4 = 32'h0;
    for (int i = 0; i < MEMN; i++) begin
      sram_mem[i]  = 16'($urandom);
      model_mem[i] = sram_mem[i];
      mem4[i]      = 16'h0;
    end

    // Reset held with a read request pending.
    @(posedge clk); #1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_dq_z", 32'(dq_oe), 32'd0);
    check("rst_h4_ready_idle", 32'(ready4), 32'd1);
    check("rst_h4_read_data", read_data4, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back({model_mem[{address[AW:2], 1'b1}], model_mem[{address[AW:2], 1'b0}]});
    wait_ready(lat);
    check("rst_release_latency", 32'(lat), 32'd5);
    check("rst_release_read", read_data, exp_q.pop_front());

    // Directed write 0x10 <- DEADBEEF.
    do_op(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, lat);
    check("wr_latency", 32'(lat), 32'd5);
    check("wr_lo_addr", 32'(tr_addr[1]), 32'd8);
    check("wr_lo_dq", 32'(tr_dq[1]), 32'h0000_BEEF);
    check("wr_lo_we", 32'(tr_we[1]), 32'd0);
    check("wr_lo_we_rel", 32'(tr_we[2]), 32'd1);
    check("wr_hi_addr", 32'(tr_addr[3]), 32'd9);
    check("wr_hi_dq", 32'(tr_dq[3]), 32'h0000_DEAD);
    check("wr_hi_we", 32'(tr_we[3]), 32'd0);
    check("wr_we_low_cycles", 32'(we_low_count(5)), 32'd2);

    // Read it back.
    do_op(1'b0, 1'b1, 32'h0000_0010, 32'h0, lat);
    check("rd_latency", 32'(lat), 32'd5);
    check("rd_word", read_data, 32'hDEAD_BEEF);
    check("rd_no_we", 32'(we_low_count(5)), 32'd0);

    // Both requests: write wins, read_data untouched.
    do_op(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, lat);
    check("both_latency", 32'(lat), 32'd5);
    check("both_keeps_rd", read_data, 32'hDEAD_BEEF);
    check("both_we_low", 32'(we_low_count(5)), 32'd2);
    do_op(1'b0, 1'b1, 32'h0000_0020, 32'h0, lat);
    check("both_written", read_data, 32'hCAFE_F00D);

    // Back-to-back write then read.
    do_op(1'b1, 1'b0, 32'h0000_0030, 32'h0123_4567, lat);
    t0 = last_start_cyc;
    check("b2b_first_ready", 32'(last_done_cyc - t0), 32'd5);
    do_op(1'b0, 1'b1, 32'h0000_0030, 32'h0, lat);
    check("b2b_second_ready", 32'(last_done_cyc - t0), 32'd11);
    check("b2b_data", read_data, 32'h0123_4567);

    // Reset during the HIGH phase of a read of 0x10.
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b1; address = 32'h0000_0010;
    repeat (3) @(posedge clk); #1;
    check("midrst_low_half", read_data, 32'h0123_BEEF);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_read_data", read_data, 32'd0);
    check("midrst_no_done", 32'(ready), 32'd0);
    check("midrst_we_n", 32'(sram_we_n), 32'd1);
    check("midrst_addr", 32'(sram_addr), 32'd8);
    rst = 1'b0;
    exp_q.push_back(32'hDEAD_BEEF);
    wait_ready(lat);
    check("midrst_reissue_lat", 32'(lat), 32'd5);
    check("midrst_reissue_data", read_data, exp_q.pop_front());

    // Request dropped mid-access: the write still completes.
    @(posedge clk); #1;
    wr_en = 1'b1; rd_en = 1'b0; address = 32'h0000_0044; write_data = 32'h5A5A_A5A5;
    repeat (2) @(posedge clk); #1;
    wr_en = 1'b0;
    repeat (4) @(posedge clk);
    do_op(1'b0, 1'b1, 32'h0000_0044, 32'h0, lat);
    check("drop_completed", read_data, 32'h5A5A_A5A5);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      a = $urandom;
      a[AW:2] = 17'($urandom_range(0, 7) * 4099);
      d = $urandom;
      do_op(kind <= 1 || kind == 3, kind >= 2, a, d, lat);
      check("rnd_latency", 32'(lat), 32'd5);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(2);

    // HALF_CYCLES = 4 instance: back-to-back write then read.
    do4(1'b1, 1'b0, 32'h0000_0124, 32'h1234_5678, lat, wl);
    t0 = last_start_cyc;
    check("h4_wr_latency", 32'(lat), 32'd9);
    check("h4_wr_we_low", 32'(wl), 32'd6);
    do4(1'b0, 1'b1, 32'h0000_0124, 32'h0, lat, wl);
    check("h4_second_ready", 32'(last_done_cyc - t0), 32'd19);
    check("h4_rd_we_low", 32'(wl), 32'd0);
    check("h4_rd_data", read_data4, 32'h1234_5678);
    @(posedge clk); #1;
    wr4 = 1'b0; rd4 = 1'b0;

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
